ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter HALT_OP, 6'd63, opcode that stops fetching.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port run, input, 1, level enable; fetching is allowed only while high.
REQ-006 Port rom_addr, output, 32, byte address driven to the combinational instruction ROM.
REQ-007 Port rom_data, input, 32, instruction returned by the ROM in the same cycle.
REQ-008 Port instr, output, 32, instruction at the head of the queue.
REQ-009 Port instr_pc, output, 32, byte address of instr.
REQ-010 Port instr_valid, output, 1, head entry is valid.
REQ-011 Port instr_ready, input, 1, decode accepts the head entry.
REQ-012 Port redirect, input, 1, branch taken; flush the queue and refetch.
REQ-013 Port redirect_pc, input, 32, byte target of redirect.
REQ-014 Port halted, output, 1, HALT_OP fetched and the queue is drained.
REQ-015 Port align_err, output, 1, sticky flag for an unaligned redirect target.

Function
REQ-016 The block SHALL be an FSM with states IDLE, FETCH, HALT and ERR.
REQ-017 IDLE->FETCH when run=1; FETCH->IDLE when run=0 (queue retained, PC held).
REQ-018 Each FETCH cycle with a free queue slot and no redirect SHALL enqueue {rom_data, pc} and set pc <= pc+4, with 32-bit wrap-around.
REQ-019 rom_addr SHALL always equal pc; the ROM read is a zero-latency combinational read.
REQ-020 The queue SHALL be a 2-entry FIFO; when it is full, no enqueue occurs and pc holds.
REQ-021 Dequeue occurs when instr_valid && instr_ready; enqueue and dequeue in the same cycle when full SHALL both succeed.
REQ-022 instr, instr_pc and instr_valid SHALL be registered queue-head outputs; latency from rom_addr=X to instr_pc=X at an empty head is 1 cycle.
REQ-023 redirect=1 SHALL flush both entries, set pc <= redirect_pc, and suppress that cycle's enqueue and dequeue; this applies in FETCH, IDLE and HALT.
REQ-024 redirect from HALT SHALL clear halted and go to FETCH if run=1, otherwise to IDLE.
REQ-025 redirect_pc[1:0] != 0 SHALL set align_err, enter ERR and leave pc unchanged; ERR is exited only by reset.
REQ-026 An enqueued word with bits [31:26]==HALT_OP SHALL be enqueued normally and then move the FSM to HALT with no further fetches.
REQ-027 halted SHALL be 1 in HALT when the queue is empty.
REQ-028 In ERR the block SHALL perform no enqueue, and instr_valid SHALL be 0.
REQ-029 rom_data SHALL be ignored in every cycle without an enqueue.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, queue empty, instr=0, instr_pc=0, instr_valid=0, halted=0 and align_err=0.
REQ-031 Reset asserted mid-fetch or mid-halt SHALL discard all queued entries; the first fetch after release is at RESET_PC.

Structure
REQ-032 The state encoding, HALT_OP and the opcode field positions SHALL live in the shared package mips_pkg.
REQ-033 The 2-entry queue SHALL be a sub-module ifq2 with push/pop/full/empty ports; the FSM and pc stay in ifetch_ctrl.

Verification
REQ-034 Reset, run=1, ROM returns lw/lw/lw/add, instr_ready=1 -> instr_pc sequence 0,4,8,12, one per cycle starting 1 cycle after the first fetch.
REQ-035 instr_ready=0 for 5 cycles -> queue holds pc 0 and 4, rom_addr stays at 8, instr_valid=1; ready=1 -> 0,4,8 delivered with no gaps.
REQ-036 redirect=1 with redirect_pc=16 while the queue holds 2 entries -> next cycle instr_valid=0, rom_addr=16; following instr_pc=16.
REQ-037 ROM word 32 = {6'd63,...} -> fetching stops after address 32; halted=1 once instr_pc=32 is consumed; rom_addr stays at 36.
REQ-038 redirect_pc=32'h0000_0006 -> align_err=1, state ERR, instr_valid=0 until reset_n=0.
REQ-039 reset_n pulsed low mid-stream, asynchronous to clk -> outputs are 0 immediately; after release with run=1 the first instr_pc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: FSM state encoding, opcode field location,
// the default halt opcode and the queue entry layout.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_e;

  localparam int          OPC_HI      = 31;
  localparam int          OPC_LO      = 26;
  localparam logic [5:0]  HALT_OPCODE = 6'd63;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/ifetch_ctrl_ifq2.sv
// Two-entry instruction queue whose head slot is itself the registered
// output, so a push into an empty queue is visible one cycle later.
module ifq2
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush_i,
  input  logic      push_i,
  input  fq_entry_t push_data_i,
  input  logic      pop_i,
  output fq_entry_t head_o,
  output logic      head_valid_o,
  output logic      full_o,
  output logic      empty_o
);

  fq_entry_t head_q, head_d, tail_q, tail_d;
  logic      hv_q, hv_d, tv_q, tv_d;

  // Pop first so that a simultaneous push lands in whichever slot the pop freed.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    hv_d   = hv_q;
    tv_d   = tv_q;
    if (flush_i) begin
      hv_d = 1'b0;
      tv_d = 1'b0;
    end else begin
      if (pop_i && hv_q) begin
        head_d = tail_q;
        hv_d   = tv_q;
        tv_d   = 1'b0;
      end
      if (push_i) begin
        if (!hv_d) begin
          head_d = push_data_i;
          hv_d   = 1'b1;
        end else begin
          tail_d = push_data_i;
          tv_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      hv_q   <= 1'b0;
      tv_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      hv_q   <= hv_d;
      tv_q   <= tv_d;
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = hv_q;
  assign full_o       = hv_q && tv_q;
  assign empty_o      = !hv_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC and the fetch FSM, reads a
// combinational ROM and feeds decode through a two-entry queue.
module ifetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = HALT_OPCODE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        align_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         halted_q, align_err_q;

  logic         push, pop, flush, full, empty, empty_next;
  fq_entry_t    head;
  logic         head_valid;

  // A redirect wins over both queue operations; a full queue still accepts a
  // push when decode drains the head in the same cycle.
  always_comb begin
    flush      = (state_q != S_ERR) && redirect;
    pop        = (state_q != S_ERR) && !redirect && head_valid && instr_ready;
    push       = (state_q == S_FETCH) && run && !redirect && (!full || pop);
    empty_next = flush || (empty && !push) || (!full && !empty && pop && !push);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else if (state_q != S_ERR) begin
      if (redirect) begin
        halted_q <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          state_q     <= S_ERR;
          align_err_q <= 1'b1;
        end else begin
          pc_q    <= redirect_pc;
          state_q <= run ? S_FETCH : S_IDLE;
        end
      end else begin
        if (push) pc_q <= pc_q + 32'd4;
        case (state_q)
          S_IDLE:  if (run) state_q <= S_FETCH;
          S_FETCH: begin
            if (!run)
              state_q <= S_IDLE;
            else if (push && (opcode_of(rom_data) == HALT_OP))
              state_q <= S_HALT;
          end
          S_HALT:  halted_q <= empty_next;
          default: ;
        endcase
      end
    end
  end

  ifq2 u_ifq (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  ('{instr: rom_data, pc: pc_q}),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign rom_addr    = pc_q;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_valid = head_valid;
  assign halted      = halted_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus a randomized
// run compared against a queue-based reference model of the fetch rules.
module tb_ifetch_ctrl;

  localparam logic [31:0] LW_BASE  = 32'h8C08_0000;
  localparam logic [31:0] ADD_WORD = 32'h0109_5020;
  localparam logic [31:0] HALT_W   = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset_n, run, instr_ready, redirect;
  logic [31:0] redirect_pc, rom_data, rom_addr, instr, instr_pc;
  logic        instr_valid, halted, align_err;

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .HALT_OP(6'd63)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .align_err   (align_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] romMem [0:63];
  entry_t      mQ[$];
  logic [31:0] mPc;
  bit          mFetching, mHalt, mErr, mAlign;
  int          checks = 0;
  int          failures = 0;

  task automatic modelReset();
    mQ.delete();
    mPc       = 32'h0;
    mFetching = 1'b0;
    mHalt     = 1'b0;
    mErr      = 1'b0;
    mAlign    = 1'b0;
  endtask

  // Reference behaviour for one clock edge, evaluated on the pre-edge inputs.
  task automatic modelStep();
    logic [31:0] word;
    bit deq, enq;
    if (mErr) return;
    if (redirect) begin
      mQ.delete();
      mHalt = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        mErr   = 1'b1;
        mAlign = 1'b1;
      end else begin
        mPc       = redirect_pc;
        mFetching = run;
      end
      return;
    end
    word = romMem[mPc[7:2]];
    deq  = (mQ.size() > 0) && instr_ready;
    enq  = mFetching && !mHalt && run && ((mQ.size() < 2) || deq);
    if (deq) void'(mQ.pop_front());
    if (enq) begin
      mQ.push_back('{instr: word, pc: mPc});
      mPc = mPc + 32'd4;
      if (word[31:26] == 6'd63) mHalt = 1'b1;
    end
    if (!mHalt) mFetching = run;
  endtask

  task automatic cycle(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
    run         = r;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    rom_data    = romMem[rom_addr[7:2]];
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    run         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #4 reset_n = 1'b1;
  endtask

  task automatic loadLw();
    for (int i = 0; i < 64; i++)
      romMem[i] = ((i % 4) == 3) ? ADD_WORD : (LW_BASE | 32'(i));
  endtask

  task automatic test_reset();
    loadLw();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b expected 0", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr_pc got %h expected 0", instr_pc); end
    checks++; if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got %h expected 0", instr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got %b expected 0", halted); end
    checks++; if (align_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_align_err got %b expected 0", align_err); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_rom_addr got %h expected 0", rom_addr); end
    doReset();
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_fetch_valid got %b expected 0", instr_valid); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("[TB] FAIL idle_rom_addr got %h expected 0", rom_addr); end
  endtask

  task automatic test_stream();
    loadLw();
    doReset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4)) begin
        failures++;
        $display("[TB] FAIL stream_pc step %0d got valid=%b pc=%h expected valid=1 pc=%h", i, instr_valid, instr_pc, 32'(i * 4));
      end
      checks++;
      if (instr !== romMem[i]) begin
        failures++;
        $display("[TB] FAIL stream_instr step %0d got %h expected %h", i, instr, romMem[i]);
      end
    end
  endtask

  task automatic test_stall();
    loadLw();
    doReset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL stall_head_pc got %h expected 0", instr_pc); end
    checks++; if (rom_addr !== 32'h8) begin failures++; $display("[TB] FAIL stall_rom_addr got %h expected 8", rom_addr); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin failures++; $display("[TB] FAIL drain_pc4 got valid=%b pc=%h expected valid=1 pc=4", instr_valid, instr_pc); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin failures++; $display("[TB] FAIL drain_pc8 got valid=%b pc=%h expected valid=1 pc=8", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect();
    logic [31:0] expPc [0:2];
    expPc[0] = 32'hFFFF_FFF8;
    expPc[1] = 32'hFFFF_FFFC;
    expPc[2] = 32'h0000_0000;
    loadLw();
    doReset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'd16);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL redirect_flush got %b expected 0", instr_valid); end
    checks++; if (rom_addr !== 32'd16) begin failures++; $display("[TB] FAIL redirect_rom_addr got %h expected 10", rom_addr); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd16) begin failures++; $display("[TB] FAIL redirect_target got valid=%b pc=%h expected valid=1 pc=10", instr_valid, instr_pc); end
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    checks++; if (rom_addr !== 32'hFFFF_FFF8) begin failures++; $display("[TB] FAIL redirect_high_addr got %h expected fffffff8", rom_addr); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== expPc[i]) begin
        failures++;
        $display("[TB] FAIL wrap_pc step %0d got valid=%b pc=%h expected valid=1 pc=%h", i, instr_valid, instr_pc, expPc[i]);
      end
    end
  endtask

  task automatic test_halt();
    loadLw();
    romMem[8] = HALT_W;
    doReset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (9) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd32) begin failures++; $display("[TB] FAIL halt_word_head got valid=%b pc=%h expected valid=1 pc=20", instr_valid, instr_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_early got %b expected 0", halted); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halted_set got %b expected 1", halted); end
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (rom_addr !== 32'd36) begin failures++; $display("[TB] FAIL halt_rom_addr got %h expected 24", rom_addr); end
    checks++; if (instr_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_hold got valid=%b halted=%b expected valid=0 halted=1", instr_valid, halted); end
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    checks++; if (halted !== 1'b0 || rom_addr !== 32'h0) begin failures++; $display("[TB] FAIL halt_exit got halted=%b addr=%h expected halted=0 addr=0", halted, rom_addr); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL halt_exit_idle got %b expected 0", instr_valid); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL halt_refetch got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc); end
  endtask

  task automatic test_align();
    loadLw();
    doReset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0006);
    checks++; if (align_err !== 1'b1) begin failures++; $display("[TB] FAIL align_err_set got %b expected 1", align_err); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL align_flush got %b expected 0", instr_valid); end
    checks++; if (rom_addr !== 32'h8) begin failures++; $display("[TB] FAIL align_pc_held got %h expected 8", rom_addr); end
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'd16);
    checks++; if (instr_valid !== 1'b0 || align_err !== 1'b1 || rom_addr !== 32'h8) begin failures++; $display("[TB] FAIL err_sticky got valid=%b err=%b addr=%h expected valid=0 err=1 addr=8", instr_valid, align_err, rom_addr); end
    doReset();
    #1;
    checks++; if (align_err !== 1'b0) begin failures++; $display("[TB] FAIL err_cleared got %b expected 0", align_err); end
  endtask

  task automatic test_async_reset();
    loadLw();
    doReset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    #3 reset_n = 1'b0;
    modelReset();
    #1;
    checks++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_head got valid=%b pc=%h instr=%h expected all 0", instr_valid, instr_pc, instr); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_pc got %h expected 0", rom_addr); end
    @(posedge clk);
    #4 reset_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL async_refetch got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc); end
  endtask

  task automatic test_random();
    logic [31:0] w, rpc;
    bit          r, rdy, rd, expValid, expHalted;
    for (int i = 0; i < 64; i++) begin
      w = $urandom();
      if (w[31:26] == 6'd63) w[31:26] = 6'd0;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'd63;
      romMem[i] = w;
    end
    doReset();
    for (int c = 0; c < 2000; c++) begin
      if (mErr && ($urandom_range(0, 9) == 0)) doReset();
      r   = ($urandom_range(0, 99) < 85);
      rdy = ($urandom_range(0, 99) < 70);
      rd  = ($urandom_range(0, 99) < 5);
      rpc = {$urandom_range(0, 1) == 0 ? 24'h0 : 24'(($urandom())), 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(r, rdy, rd, rpc);
      expValid  = (mQ.size() != 0);
      expHalted = mHalt && (mQ.size() == 0);
      checks++;
      if (instr_valid !== expValid) begin failures++; $display("[TB] FAIL rand_valid cycle %0d got %b expected %b", c, instr_valid, expValid); end
      checks++;
      if (rom_addr !== mPc) begin failures++; $display("[TB] FAIL rand_rom_addr cycle %0d got %h expected %h", c, rom_addr, mPc); end
      checks++;
      if (halted !== expHalted || align_err !== mAlign) begin failures++; $display("[TB] FAIL rand_flags cycle %0d got halted=%b err=%b expected halted=%b err=%b", c, halted, align_err, expHalted, mAlign); end
      if (expValid) begin
        checks++;
        if (instr_pc !== mQ[0].pc || instr !== mQ[0].instr) begin
          failures++;
          $display("[TB] FAIL rand_head cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", c, instr_pc, instr, mQ[0].pc, mQ[0].instr);
        end
      end
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    run         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rom_data    = 32'h0;
    modelReset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_align();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
